// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer SPI sequencer: register map, FSM enums, helpers.
// Optional WHO_AM_I probe states are present only when WHOAMI_CHECK_EN is defined.
`timescale 1ns/1ps
package accel_pkg;

    localparam logic [7:0] REG_WHO_AM_I = 8'h0F;
    localparam logic [7:0] REG_CTRL1    = 8'h20;
    localparam logic [7:0] REG_CTRL4    = 8'h23;
    localparam logic [7:0] REG_OUT_X_L  = 8'h28;
    localparam logic [7:0] WHOAMI_VAL   = 8'h33;
    localparam logic [2:0] LAST_IDX     = 3'd5;

    typedef enum logic [2:0] {
        ST_CFG1,
        ST_CFG4,
        ST_IDLE,
        ST_RD,
        ST_PUBLISH
`ifdef WHOAMI_CHECK_EN
        , ST_ID,
        ST_ID_WAIT
`endif
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_BUSY
    } phase_e;

    // States that own an SPI transaction (ISSUE/BUSY phases apply)
    function automatic logic is_access(input state_e s);
        case (s)
            ST_CFG1, ST_CFG4, ST_RD: return 1'b1;
`ifdef WHOAMI_CHECK_EN
            ST_ID:                   return 1'b1;
`endif
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sample_timer.sv
// Free-running modulo-DIV counter, enabled once start_i is high; tick_o marks the wrap cycle.
`timescale 1ns/1ps
module sample_timer #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic tick_o
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Wrap detection and next count
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (start_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d  = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

endmodule

// File: rtl/accel_ctrl.sv
// Accelerometer sequencer: configures the sensor, then periodically burst-reads X/Y/Z over SPI.
// Define WHOAMI_CHECK_EN to probe WHO_AM_I before configuration and expose id_err.
`timescale 1ns/1ps
module accel_ctrl
    import accel_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter logic [7:0]  CTRL1_VAL  = 8'h57,
    parameter logic [7:0]  CTRL4_VAL  = 8'h08
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [7:0]  spi_addr,
    output logic [7:0]  spi_wdata,
    output logic        spi_read,
    output logic        spi_enable,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_done,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [15:0] z_out,
    output logic        sample_valid,
    output logic        init_done,
    output logic        overrun
`ifdef WHOAMI_CHECK_EN
    ,
    output logic        id_err
`endif
);

`ifdef WHOAMI_CHECK_EN
    localparam state_e RESET_STATE = ST_ID;
`else
    localparam state_e RESET_STATE = ST_CFG1;
`endif

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0][7:0]  stage_q, stage_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             init_done_q, init_done_d;
    logic             valid_q, valid_d;
    logic [15:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic             tick_s;
    logic             done_s;
`ifdef WHOAMI_CHECK_EN
    logic [7:0]       wait_q, wait_d;
    logic             id_err_q, id_err_d;
`endif

    sample_timer #(.DIV(SAMPLE_DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (init_done_q),
        .tick_o  (tick_s)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            phase_q     <= PH_ISSUE;
            idx_q       <= 3'd0;
            stage_q     <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            init_done_q <= 1'b0;
            valid_q     <= 1'b0;
            x_q         <= 16'h0000;
            y_q         <= 16'h0000;
            z_q         <= 16'h0000;
`ifdef WHOAMI_CHECK_EN
            wait_q      <= 8'h00;
            id_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            init_done_q <= init_done_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
`ifdef WHOAMI_CHECK_EN
            wait_q      <= wait_d;
            id_err_q    <= id_err_d;
`endif
        end
    end

    assign done_s = is_access(state_q) && (phase_q == PH_BUSY) && spi_done;

    // Sequencing, transaction phases, sample assembly and tick bookkeeping
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        stage_d     = stage_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        init_done_d = init_done_q;
        valid_d     = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
`ifdef WHOAMI_CHECK_EN
        wait_d      = wait_q;
        id_err_d    = id_err_q;
`endif

        if (is_access(state_q)) begin
            if (phase_q == PH_ISSUE) begin
                phase_d = PH_BUSY;
            end else if (spi_done) begin
                phase_d = PH_ISSUE;
            end else begin
                phase_d = PH_BUSY;
            end
        end else begin
            phase_d = PH_ISSUE;
        end

        case (state_q)
            ST_CFG1: begin
                if (done_s) begin
                    state_d = ST_CFG4;
                end else begin
                    state_d = ST_CFG1;
                end
            end
            ST_CFG4: begin
                if (done_s) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    state_d = ST_CFG4;
                end
            end
            ST_IDLE: begin
                if ((tick_s || pending_q) && run) begin
                    state_d   = ST_RD;
                    idx_d     = 3'd0;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (done_s) begin
                    if (idx_q == LAST_IDX) begin
                        // Last byte is used straight off the bus so all axes update together
                        state_d = ST_PUBLISH;
                        x_d     = {stage_q[1], stage_q[0]};
                        y_d     = {stage_q[3], stage_q[2]};
                        z_d     = {spi_rdata, stage_q[4]};
                        valid_d = 1'b1;
                    end else begin
                        stage_d[idx_q] = spi_rdata;
                        idx_d          = idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
`ifdef WHOAMI_CHECK_EN
            ST_ID: begin
                if (done_s) begin
                    if (spi_rdata == WHOAMI_VAL) begin
                        id_err_d = 1'b0;
                        state_d  = ST_CFG1;
                    end else begin
                        id_err_d = 1'b1;
                        wait_d   = 8'h00;
                        state_d  = ST_ID_WAIT;
                    end
                end else begin
                    state_d = ST_ID;
                end
            end
            ST_ID_WAIT: begin
                if (wait_q == 8'hFF) begin
                    state_d = ST_ID;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = RESET_STATE;
                phase_d = PH_ISSUE;
            end
        endcase

        // Ticks in IDLE are consumed (or discarded) by the IDLE branch above
        if (tick_s && (state_q != ST_IDLE)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_d;
        end
    end

    // SPI request decode; held quiet while reset is asserted
    always_comb begin
        spi_addr   = 8'h00;
        spi_wdata  = 8'h00;
        spi_read   = 1'b0;
        spi_enable = 1'b0;
        if (!reset) begin
            spi_enable = is_access(state_q) && (phase_q == PH_ISSUE);
            case (state_q)
                ST_CFG1: begin
                    spi_addr  = REG_CTRL1;
                    spi_wdata = CTRL1_VAL;
                end
                ST_CFG4: begin
                    spi_addr  = REG_CTRL4;
                    spi_wdata = CTRL4_VAL;
                end
                ST_RD: begin
                    spi_addr = REG_OUT_X_L + {5'd0, idx_q};
                    spi_read = 1'b1;
                end
`ifdef WHOAMI_CHECK_EN
                ST_ID: begin
                    spi_addr = REG_WHO_AM_I;
                    spi_read = 1'b1;
                end
`endif
                default: begin
                    spi_addr = 8'h00;
                end
            endcase
        end else begin
            spi_enable = 1'b0;
        end
    end

    assign x_out        = x_q;
    assign y_out        = y_q;
    assign z_out        = z_q;
    assign sample_valid = valid_q;
    assign init_done    = init_done_q;
    assign overrun      = overrun_q;
`ifdef WHOAMI_CHECK_EN
    assign id_err       = id_err_q;
`endif

endmodule

// File: tb/tb_accel_ctrl.sv
// Directed bench for accel_ctrl with a behavioural SPI responder of adjustable latency.
`timescale 1ns/1ps
module tb_accel_ctrl;

    localparam int unsigned DIV = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  spi_addr, spi_wdata, spi_rdata;
    logic        spi_read, spi_enable, spi_done;
    logic [15:0] x_out, y_out, z_out;
    logic        sample_valid, init_done, overrun;
`ifdef WHOAMI_CHECK_EN
    logic        id_err;
`endif

    always #5 clk = ~clk;

    accel_ctrl #(.SAMPLE_DIV(DIV), .CTRL1_VAL(8'h57), .CTRL4_VAL(8'h08)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_read     (spi_read),
        .spi_enable   (spi_enable),
        .spi_rdata    (spi_rdata),
        .spi_done     (spi_done),
        .x_out        (x_out),
        .y_out        (y_out),
        .z_out        (z_out),
        .sample_valid (sample_valid),
        .init_done    (init_done),
        .overrun      (overrun)
`ifdef WHOAMI_CHECK_EN
        ,
        .id_err       (id_err)
`endif
    );

    // Responder state and transaction log
    int         cyc = 0;
    int         lat = 33;
    int         m_cnt = 0;
    logic       m_busy = 1'b0;
    logic [7:0] m_addr = 8'h00;
    int         done_cyc = 0;
    int         n_tx = 0;
    int         viol = 0;
    logic [7:0] rd_tab  [6];
    logic [7:0] log_addr [64];
    logic [7:0] log_wdat [64];
    logic       log_rd   [64];

    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI responder: done exactly lat cycles after the enable cycle
    always @(posedge clk) begin
        if (reset) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            spi_done  <= 1'b0;
            spi_rdata <= 8'h00;
        end else begin
            spi_done <= 1'b0;
            if (spi_enable) begin
                if (m_busy || spi_done) viol <= viol + 1;
                m_busy             <= 1'b1;
                m_cnt              <= lat - 1;
                m_addr             <= spi_addr;
                log_addr[n_tx & 63] <= spi_addr;
                log_wdat[n_tx & 63] <= spi_wdata;
                log_rd[n_tx & 63]   <= spi_read;
                n_tx               <= n_tx + 1;
            end else if (m_busy) begin
                if (spi_addr != m_addr) viol <= viol + 1;
                if (m_cnt == 1) begin
                    spi_done  <= 1'b1;
                    m_busy    <= 1'b0;
                    done_cyc  <= cyc + 1;
                    spi_rdata <= (m_addr >= 8'h28 && m_addr <= 8'h2D) ? rd_tab[m_addr - 8'h28] : 8'h00;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = init_done, 1 = sample_valid, 2 = spi_enable
    task automatic wait_sig(input int sel, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            case (sel)
                0: ok = init_done;
                1: ok = sample_valid;
                default: ok = spi_enable;
            endcase
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_val({tag, "_x"}, x_out, 32'h0);
        check_val({tag, "_y"}, y_out, 32'h0);
        check_val({tag, "_z"}, z_out, 32'h0);
        check_val({tag, "_valid"}, sample_valid, 32'h0);
        check_val({tag, "_init"}, init_done, 32'h0);
        check_val({tag, "_ovr"}, overrun, 32'h0);
        check_val({tag, "_en"}, spi_enable, 32'h0);
        check_val({tag, "_addr"}, spi_addr, 32'h0);
        check_val({tag, "_rd"}, spi_read, 32'h0);
    endtask

    initial begin
        bit ok;
        int base;
        int en_cnt;
        int vcnt;
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 6; i++) rd_tab[i] = 8'h10 * 8'(i + 1);
        repeat (3) @(negedge clk);
        check_quiet_outputs("rst");

        // Configuration writes
        base  = n_tx;
        reset = 1'b0;
        wait_sig(0, 200, ok);
        check_val("init_rise", ok, 32'h1);
        check_val("init_cycle", cyc, done_cyc + 1);
        check_val("cfg_count", n_tx - base, 32'd2);
        check_val("cfg0_addr", log_addr[base & 63], 32'h20);
        check_val("cfg0_data", log_wdat[base & 63], 32'h57);
        check_val("cfg0_rd", log_rd[base & 63], 32'h0);
        check_val("cfg1_addr", log_addr[(base + 1) & 63], 32'h23);
        check_val("cfg1_data", log_wdat[(base + 1) & 63], 32'h08);
        check_val("cfg1_rd", log_rd[(base + 1) & 63], 32'h0);

        // run=0: nothing happens for three sample periods
        en_cnt = 0;
        vcnt   = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (spi_enable) en_cnt++;
            if (sample_valid) vcnt++;
        end
        check_val("quiet_enables", en_cnt, 32'd0);
        check_val("quiet_valids", vcnt, 32'd0);

        // First burst: 0x10..0x60
        base = n_tx;
        run  = 1'b1;
        wait_sig(2, DIV + 1, ok);
        check_val("burst_start", ok, 32'h1);
        wait_sig(1, 300, ok);
        check_val("sample1_seen", ok, 32'h1);
        check_val("x1", x_out, 32'h2010);
        check_val("y1", y_out, 32'h4030);
        check_val("z1", z_out, 32'h6050);
        @(negedge clk);
        run = 1'b0;
        check_val("valid_pulse", sample_valid, 32'h0);
        check_val("rd_count", n_tx - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val("rd_addr", log_addr[(base + i) & 63], 32'h28 + 32'(i));
            check_val("rd_flag", log_rd[(base + i) & 63], 32'h1);
            check_val("rd_wdata", log_wdat[(base + i) & 63], 32'h0);
        end

        // Signed data
        rd_tab[0] = 8'hFF; rd_tab[1] = 8'hFF; rd_tab[2] = 8'h00;
        rd_tab[3] = 8'h80; rd_tab[4] = 8'h01; rd_tab[5] = 8'h00;
        run = 1'b1;
        wait_sig(1, 600, ok);
        check_val("sample2_seen", ok, 32'h1);
        check_val("x2", x_out, 32'hFFFF);
        check_val("x2_signed", 32'($signed(x_out)), 32'hFFFF_FFFF);
        check_val("y2", y_out, 32'h8000);
        check_val("z2", z_out, 32'h0001);
        @(negedge clk);
        run = 1'b0;
        check_val("ovr_before", overrun, 32'h0);

        // Stretched transactions: burst spans more than two sample periods
        lat = 100;
        run = 1'b1;
        wait_sig(1, 1000, ok);
        check_val("sample3_seen", ok, 32'h1);
        check_val("overrun_set", overrun, 32'h1);
        lat = 33;
        @(negedge clk);
        check_val("idle_gap_en", spi_enable, 32'h0);
        @(negedge clk);
        check_val("rerun_en", spi_enable, 32'h1);
        check_val("rerun_addr", spi_addr, 32'h28);

        // Reset during BUSY of the third read
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = spi_enable && (spi_addr == 8'h2A);
        end
        check_val("third_read_seen", ok, 32'h1);
        repeat (5) @(negedge clk);
        check_val("busy_no_en", spi_enable, 32'h0);
        check_val("busy_addr", spi_addr, 32'h2A);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        check_quiet_outputs("midrst");
        base  = n_tx;
        reset = 1'b0;
        wait_sig(0, 200, ok);
        check_val("reinit_rise", ok, 32'h1);
        check_val("reinit_count", n_tx - base, 32'd2);
        check_val("reinit_addr0", log_addr[base & 63], 32'h20);
        check_val("reinit_addr1", log_addr[(base + 1) & 63], 32'h23);
        check_val("reinit_ovr", overrun, 32'h0);
        check_val("protocol_viol", viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/accel_ctrl.md
Name: accel_ctrl

Overview:
Sequencer that drives the SPI master of the 3-axis accelerometer.
- After reset it writes two configuration registers.
- It then periodically burst-reads the six output registers OUT_X_L..OUT_Z_H (0x28..0x2D), one byte per SPI transaction.
- It assembles signed 16-bit X/Y/Z samples and presents them downstream with a one-cycle valid strobe.
- It sits directly upstream of spi, connecting to its addr/wdata/read/enable/rdata/done.

Parameters:
SAMPLE_DIV, 100000, sample period in clk cycles (>= 256)
CTRL1_VAL, 8'h57, value written to CTRL_REG1 (0x20)
CTRL4_VAL, 8'h08, value written to CTRL_REG4 (0x23)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
run  input  1  sampling enable; sampled only in IDLE
spi_addr  output  8  register address to spi; bit 7 always 0
spi_wdata  output  8  write data to spi
spi_read  output  1  1 = read transaction
spi_enable  output  1  one-cycle start pulse to spi
spi_rdata  input  8  read byte from spi; valid while spi_done=1
spi_done  input  1  one-cycle end-of-transaction strobe from spi
x_out  output  16  signed X sample, {OUT_X_H, OUT_X_L}
y_out  output  16  signed Y sample
z_out  output  16  signed Z sample
sample_valid  output  1  one-cycle pulse; x/y/z updated this cycle
init_done  output  1  high once configuration writes complete
overrun  output  1  sticky; a sample tick was dropped

Behaviour:
Reset values:
- All outputs are 0, state = CFG1.
- The byte index, timer, pending flag and staging registers are cleared.

Transaction protocol:
- Each SPI access takes two phases: ISSUE, then BUSY.
- ISSUE lasts exactly 1 cycle. In it, spi_enable=1 and spi_addr/spi_wdata/spi_read are driven.
- BUSY holds spi_addr/spi_wdata/spi_read stable with spi_enable=0 until spi_done=1.
- On the spi_done cycle, spi_rdata is latched if the access is a read.
- The next ISSUE may occur the cycle after spi_done.
- spi_enable is never asserted in BUSY or on a spi_done cycle.
- With the paired spi, spi_done arrives 33 cycles after ISSUE. Each access therefore occupies 34 cycles.

State sequence:
- CFG1: write 0x20 <- CTRL1_VAL.
- CFG4: write 0x23 <- CTRL4_VAL.
- After CFG4 completes: init_done <= 1 (stays set until reset), go to IDLE.
- IDLE: if (tick or pending) and run, go to RD with idx=0 and clear pending; otherwise stay.
- RD: read address 0x28+idx, with spi_wdata=0 and spi_read=1.
  - On done, stage[idx] <= spi_rdata.
  - If idx<5: idx++ and ISSUE the next read.
  - If idx=5: go to PUBLISH.
- PUBLISH (1 cycle):
  - x_out={stage1,stage0}; y_out={stage3,stage2}; z_out={spi byte 5,stage4}.
  - sample_valid=1, then return to IDLE.
- x/y/z are updated only in PUBLISH, all three on the same cycle. They hold between samples.

Timer:
- Starts counting when init_done rises. Wraps at SAMPLE_DIV-1 and pulses tick on the wrap cycle.
- Runs regardless of state and regardless of run.
- Tick outside IDLE sets pending.
- Tick while pending is already 1 sets overrun (sticky until reset); the tick is dropped.
- Tick in IDLE with run=0 is discarded and does not set pending.

Boundary conditions:
- Tick and PUBLISH on the same cycle: pending <= 1, and the burst starts on the following IDLE cycle.
- run deasserted mid-burst: the burst completes and publishes, then the block idles.
- Reset mid-transaction: immediate return to the reset state. The spi shares the reset, so no stale spi_done is possible.

Optional Feature:
WHOAMI_CHECK_EN
- Defined:
  - Before CFG1, the block reads WHO_AM_I (0x0F).
  - If the byte equals 8'h33, it proceeds to CFG1.
  - Otherwise it retries after 256 idle cycles, indefinitely, and init_done stays 0.
  - Adds output id_err (1 bit, reset 0). It is set on a mismatch and cleared on a match.
- Undefined:
  - No WHO_AM_I access and no id_err port; the block starts at CFG1.

Decomposition:
- accel_pkg holds:
  - Register address localparams: REG_WHO_AM_I=0x0F, REG_CTRL1=0x20, REG_CTRL4=0x23, REG_OUT_X_L=0x28.
  - WHOAMI_VAL=8'h33.
  - The state enum {CFG1, CFG4, IDLE, RD, PUBLISH, plus ID/ID_WAIT when enabled}.
  - The phase enum {ISSUE, BUSY}.
- One sub-module, sample_timer: a modulo-SAMPLE_DIV counter with start and tick ports.

Test Plan:
- Reset, then a behavioural spi model (done 33 cycles after enable) -> exactly 2 writes: (0x20, 0x57, read=0) then (0x23, 0x08, read=0); init_done rises on the cycle after the second done.
- Model returns bytes 0x10,0x20,0x30,0x40,0x50,0x60 for 0x28..0x2D, run=1 -> 6 reads at increasing addresses; single sample_valid pulse with x=0x2010, y=0x4030, z=0x6050.
- Signed data: bytes 0xFF,0xFF,0x00,0x80,0x01,0x00 -> x=0xFFFF (-1), y=0x8000, z=0x0001.
- SAMPLE_DIV=256 with the model stretched so a burst takes >512 cycles -> overrun=1; the next burst still starts immediately after PUBLISH.
- run=0 -> no spi_enable after init for 3*SAMPLE_DIV cycles; run=1 -> burst begins within SAMPLE_DIV+1 cycles.
- Reset asserted during the 3rd read's BUSY -> all outputs 0 on the next cycle, then the sequence restarts at CFG1. With WHOAMI_CHECK_EN and a 0x32 reply -> id_err=1, a retry 256 cycles later, and no CFG writes.
